// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: consumes A and B LSB first, one qualified bit per cycle,
// and assembles the WIDTH-bit difference A-B-borrow_in plus the final borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             borrow_in,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             abort,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_br;

  logic w_d;
  logic w_nbr;
  logic w_accept;
  logic w_last;
  logic w_load;

  assign w_d      = a_bit ^ b_bit ^ r_br;
  assign w_nbr    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & r_br);
  // abort wins over a bit arriving in the same cycle
  assign w_accept = (r_state == S_RUN) && bit_valid && !abort;
  assign w_last   = w_accept && (r_cnt == CW'(WIDTH - 1));
  assign w_load   = (r_state == S_IDLE) && start;

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_bit   <= 1'b0;
      diff_valid <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      r_cnt      <= '0;
      r_br       <= 1'b0;
    end else begin
      diff_valid <= w_accept;
      if (w_load) begin
        r_br       <= borrow_in;
        r_cnt      <= '0;
        result     <= '0;
        borrow_out <= 1'b0;
      end else if (w_accept) begin
        diff_bit <= w_d;
        r_br     <= w_nbr;
        result   <= {w_d, result[WIDTH-1:1]};
        // counter parks on WIDTH-1 for the last bit so it never wraps
        if (w_last) begin
          borrow_out <= w_nbr;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random
// operations compared against an arithmetic A-B-borrow_in reference.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         borrow_in;
  logic         bit_valid;
  logic         a_bit;
  logic         b_bit;
  logic         abort;
  logic         diff_bit;
  logic         diff_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow_out;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .borrow_in (borrow_in),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .abort     (abort),
    .diff_bit  (diff_bit),
    .diff_valid(diff_valid),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .borrow_out(borrow_out)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; gaps of gap_len idle cycles follow each bit flagged in gap_mask.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] gap_mask, input int gap_len,
                        input int start_at, input logic abort_with_start);
    logic [31:0]  full;
    logic [W-1:0] exp_r;
    logic         exp_bo;
    int           d0;
    full   = 32'(a) - 32'(b) - 32'(bin);
    exp_r  = full[W-1:0];
    exp_bo = (int'(a) < int'(b) + int'(bin));
    d0     = done_cnt;

    start = 1'b1; borrow_in = bin; abort = abort_with_start; bit_valid = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0; borrow_in = ~bin;
    check_eq("busy_after_start", 32'(busy), 32'(1));
    check_eq("result_cleared", 32'(result), 32'(0));

    for (int i = 0; i < W; i++) begin
      a_bit = a[i]; b_bit = b[i]; bit_valid = 1'b1;
      start = (i == start_at);
      tick();
      start = 1'b0;
      check_eq("diff_valid", 32'(diff_valid), 32'(1));
      check_eq("diff_bit", 32'(diff_bit), 32'(exp_r[i]));
      check_eq("done_timing", 32'(done), 32'(i == W - 1));
      check_eq("busy_run", 32'(busy), 32'(i != W - 1));
      if (i != W - 1 && gap_mask[i] && gap_len > 0) begin
        bit_valid = 1'b0;
        a_bit = 1'($urandom); b_bit = 1'($urandom);
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check_eq("gap_diff_valid", 32'(diff_valid), 32'(0));
          check_eq("gap_busy", 32'(busy), 32'(1));
        end
      end
    end

    // bit_valid and start presented during DONE must both be ignored
    bit_valid = 1'b1; start = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
    tick();
    bit_valid = 1'b0; start = 1'b0;
    check_eq("idle_busy", 32'(busy), 32'(0));
    check_eq("idle_done", 32'(done), 32'(0));
    check_eq("done_diff_valid", 32'(diff_valid), 32'(0));
    check_eq("result", 32'(result), 32'(exp_r));
    check_eq("borrow_out", 32'(borrow_out), 32'(exp_bo));
    check_eq("done_count", 32'(done_cnt - d0), 32'(1));

    // bit_valid in IDLE is ignored and results hold
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    check_eq("idle_diff_valid", 32'(diff_valid), 32'(0));
    check_eq("result_hold", 32'(result), 32'(exp_r));
    $display("op a=%02h b=%02h bin=%0d result=%02h borrow_out=%0d exp=%02h/%0d",
             a, b, bin, result, borrow_out, exp_r, exp_bo);
  endtask

  task automatic partial_bits(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    start = 1'b1; borrow_in = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      a_bit = a[i]; b_bit = b[i]; bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    logic [31:0]  full;
    logic [W-1:0] pr;
    int           d0;
    rst_n = 1'b0; start = 1'b0; borrow_in = 1'b0; bit_valid = 1'b0;
    a_bit = 1'b0; b_bit = 1'b0; abort = 1'b0;
    #12;
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_diff_valid", 32'(diff_valid), 32'(0));
    check_eq("rst_result", 32'(result), 32'(0));
    check_eq("rst_borrow_out", 32'(borrow_out), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_op(8'h05, 8'h03, 1'b0, 8'h00, 0, -1, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 8'h00, 0, -1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'h00, 0, -1, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b0, 8'b0010_0100, 3, -1, 1'b0);
    run_op(8'h3C, 8'h21, 1'b0, 8'h00, 0, 3, 1'b0);
    run_op(8'h77, 8'h78, 1'b1, 8'h00, 0, -1, 1'b1);

    // abort after four bits, with a coincident bit_valid that must lose
    d0 = done_cnt;
    partial_bits(8'hFF, 8'h01, 4);
    abort = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    full = 32'(8'hFF) - 32'(8'h01);
    pr   = W'(full[3:0]) << (W - 4);
    check_eq("abort_busy", 32'(busy), 32'(0));
    check_eq("abort_diff_valid", 32'(diff_valid), 32'(0));
    check_eq("abort_result", 32'(result), 32'(pr));
    tick();
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'(0));
    $display("abort result=%02h exp=%02h", result, pr);
    run_op(8'h10, 8'h01, 1'b0, 8'h00, 0, -1, 1'b0);

    // asynchronous reset between clock edges mid-operation
    d0 = done_cnt;
    partial_bits(8'hFF, 8'h00, 3);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'(0));
    check_eq("arst_diff_bit", 32'(diff_bit), 32'(0));
    check_eq("arst_diff_valid", 32'(diff_valid), 32'(0));
    check_eq("arst_result", 32'(result), 32'(0));
    check_eq("arst_borrow_out", 32'(borrow_out), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    check_eq("arst_no_done", 32'(done_cnt - d0), 32'(0));
    $display("reset mid-run result=%02h busy=%0d", result, busy);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 0, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand length in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: begin a new subtraction, honoured only in IDLE.
REQ-005 The block SHALL have port borrow_in, input, 1 bit: initial borrow, sampled on the start cycle.
REQ-006 The block SHALL have port bit_valid, input, 1 bit: a_bit and b_bit are valid this cycle.
REQ-007 The block SHALL have ports a_bit and b_bit, inputs, 1 bit each: minuend and subtrahend bits, presented LSB first.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-009 The block SHALL have port diff_bit, output, 1 bit: registered difference bit.
REQ-010 The block SHALL have port diff_valid, output, 1 bit: one-cycle qualifier for diff_bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port result, output, WIDTH bits: the assembled difference A-B-borrow_in.
REQ-014 The block SHALL have port borrow_out, output, 1 bit: the final borrow, where 1 means A < B+borrow_in.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 From IDLE, start=1 SHALL move the FSM to RUN, load the borrow register from borrow_in, clear the bit counter, and clear result to 0.
REQ-017 In RUN with bit_valid=1, the block SHALL compute d = a^b^br and nbr = (~a&b) | (~(a^b)&br).
  - On the same edge it SHALL register diff_bit<=d and diff_valid<=1, set br<=nbr, and shift result<={d, result[WIDTH-1:1]}.
  - It SHALL then increment the counter.
REQ-018 In RUN with bit_valid=0, the block SHALL hold all state, and diff_valid SHALL be 0 on the next cycle.
REQ-019 Latency: diff_bit/diff_valid SHALL appear the cycle after the bit is sampled.
REQ-020 When the WIDTH-th valid bit is accepted (counter==WIDTH-1 with bit_valid=1), the FSM SHALL go to DONE and load borrow_out<=nbr.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=0, then return to IDLE unconditionally.
  - done SHALL coincide with diff_valid for the final bit.
REQ-022 result and borrow_out SHALL hold their values from DONE until the next accepted start.
REQ-023 start while in RUN or DONE SHALL be ignored.
REQ-024 bit_valid in IDLE or DONE SHALL be ignored, with diff_valid remaining 0.
REQ-025 abort=1 in RUN SHALL return the FSM to IDLE next edge, with no done pulse, and SHALL leave result and borrow_out unchanged from their values at abort.
  - abort SHALL take priority over a simultaneous bit_valid.
  - abort outside RUN SHALL be ignored.
REQ-026 Start and abort in the same IDLE cycle SHALL resolve to start, because abort is ignored outside RUN.
REQ-027 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within an operation.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and set diff_bit, diff_valid, busy, done, result, borrow_out, the counter and br all to 0, independent of clk.
REQ-029 Reset asserted mid-RUN SHALL discard the operation, and no done SHALL follow.
REQ-030 After rst_n deasserts, the first accepted start SHALL behave as a fresh operation.

Verification (WIDTH=8)
REQ-031 Scenario: A=0x05, B=0x03, borrow_in=0, bit_valid continuous -> busy for 8 cycles, diff_valid bits LSB-first 0,1,0,0,0,0,0,0, done 1 cycle, result=0x02, borrow_out=0.
REQ-032 Scenario: A=0x03, B=0x05, borrow_in=0 -> result=0xFE, borrow_out=1; a subsequent A=0x00, B=0x00, borrow_in=1 -> result=0xFF, borrow_out=1.
REQ-033 Scenario: A=0xA5, B=0x5A with bit_valid deasserted for 3 cycles after bits 2 and 5 -> result=0x4B, borrow_out=0, done 3+3 cycles later than the gap-free case, diff_valid=0 during the gaps.
REQ-034 Scenario: start pulsed again during RUN -> no restart, result matches the single-op value, exactly one done.
REQ-035 Scenario: abort after 4 bits of A=0xFF, B=0x01 -> IDLE next cycle, no done, busy=0; the next full op A=0x10, B=0x01 -> result=0x0F.
REQ-036 Scenario: rst_n pulsed low between clock edges mid-RUN -> all outputs 0 immediately, no done; a fresh op A=0x80, B=0x80 -> result=0x00, borrow_out=0.
